mem_block_responder: RTL and testbench

- Memory-side responder for the cache controller's block-refill/write-back interface: accepts mem_req_* requests, models a fixed-latency block memory, returns a 512-bit line or commits a dirty line.
- Sits below cache_controller as main-memory model in integration benches; synthesizable for FPGA bring-up.
- One request outstanding at a time; single-cycle ready pulse per request.

---
 rtl/mem_block_responder_pkg.sv | 25 ++
 rtl/mem_block_responder_if.sv | 23 ++
 rtl/mem_block_ram.sv | 30 +++
 rtl/mem_block_responder.sv | 140 ++++++++++++++
 tb/tb_mem_block_responder.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_block_responder_pkg.sv
// Shared types and constants for mem_block_responder and its storage array.
// The INIT pattern helper is used only when MEM_BLOCK_RESPONDER_INIT_EN is defined.
package mem_block_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StInit
  } state_e;

  localparam int unsigned DefBlockOffset   = 4;
  localparam int unsigned DefIndexBits     = 8;
  localparam int unsigned BYTE_OFFSET_BITS = DefBlockOffset + 2;
  localparam int unsigned MEM_LINES        = 2 ** DefIndexBits;

  localparam logic [31:0] INIT_PATTERN_BASE = 32'hDEADBEEF;

  // Given word of the given line in the power-up fill pattern.
  function automatic logic [31:0] init_word(int unsigned line, int unsigned word,
                                            int unsigned block_offset);
    return INIT_PATTERN_BASE + 32'((line << block_offset) + word);
  endfunction

endpackage

// File: rtl/mem_block_responder_if.sv
// Block refill / write-back request channel between cache controller and memory.
interface mem_block_responder_if #(
  parameter int unsigned WORD_SIZE        = 32,
  parameter int unsigned BLOCK_DATA_WIDTH = 512
);
  logic                        mem_req_enable;
  logic                        mem_req_rw;
  logic [WORD_SIZE-1:0]        mem_req_addr;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain;
  logic                        mem_req_ready;
  logic                        mem_busy;

  modport master (
    output mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
    input  mem_req_datain, mem_req_ready, mem_busy
  );

  modport slave (
    input  mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
    output mem_req_datain, mem_req_ready, mem_busy
  );
endinterface

// File: rtl/mem_block_ram.sv
// Single-port line array with registered read; rdata only changes on a read access.
module mem_block_ram #(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] lines_q [2**INDEX_BITS];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      lines_q[index] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= lines_q[index];
    end
  end
endmodule

// File: rtl/mem_block_responder.sv
// Fixed-latency block memory responder for cache refill / write-back traffic.
// Define MEM_BLOCK_RESPONDER_INIT_EN to fill the array with a known pattern after reset.
module mem_block_responder
  import mem_block_responder_pkg::*;
#(
  parameter int unsigned WORD_SIZE        = 32,
  parameter int unsigned BLOCK_OFFSET     = BYTE_OFFSET_BITS - 2,
  parameter int unsigned BLOCK_DATA_WIDTH = 512,
  parameter int unsigned MEM_INDEX_BITS   = $clog2(MEM_LINES),
  parameter int unsigned LATENCY          = 4
) (
  input logic                  clk,
  input logic                  rst,
  mem_block_responder_if.slave mem
);
  localparam int unsigned IdxLo   = BLOCK_OFFSET + 2;
  localparam int unsigned Words   = BLOCK_DATA_WIDTH / WORD_SIZE;
  localparam logic [7:0]  CntLoad = 8'(LATENCY - 1);

  state_e                      state_q;
  logic [7:0]                  cnt_q;
  logic                        armed_q, ready_q, busy_q, rw_q;
  logic [MEM_INDEX_BITS-1:0]   idx_q;
  logic [BLOCK_DATA_WIDTH-1:0] wdata_q;
  logic                        accept, fire;
  logic                        ram_we, ram_re;
  logic [MEM_INDEX_BITS-1:0]   ram_idx;
  logic [BLOCK_DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic                        unused_addr;

`ifdef MEM_BLOCK_RESPONDER_INIT_EN
  logic [MEM_INDEX_BITS-1:0]   init_idx_q;
`endif

  assign accept      = (state_q == StIdle) && mem.mem_req_enable && armed_q;
  // Access happens on the last WAIT edge; LATENCY=1 passes through WAIT with the counter at 0,
  // which keeps ready at exactly accept+LATENCY.
  assign fire        = (state_q == StWait) && (cnt_q == 8'd0);
  assign unused_addr = ^mem.mem_req_addr;

  always_comb begin
    ram_we    = !rst && fire && rw_q;
    ram_re    = !rst && fire && !rw_q;
    ram_idx   = idx_q;
    ram_wdata = wdata_q;
`ifdef MEM_BLOCK_RESPONDER_INIT_EN
    if (state_q == StInit) begin
      ram_we  = !rst;
      ram_re  = 1'b0;
      ram_idx = init_idx_q;
      for (int w = 0; w < Words; w++) begin
        ram_wdata[w*WORD_SIZE +: WORD_SIZE] =
          WORD_SIZE'(init_word(int unsigned'(init_idx_q), int unsigned'(w), BLOCK_OFFSET));
      end
    end
`endif
  end

  // Request fields are frozen at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= mem.mem_req_rw;
      idx_q   <= mem.mem_req_addr[IdxLo +: MEM_INDEX_BITS];
      wdata_q <= mem.mem_req_dataout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MEM_BLOCK_RESPONDER_INIT_EN
      state_q    <= StInit;
      busy_q     <= 1'b1;
      init_idx_q <= '0;
`else
      state_q    <= StIdle;
      busy_q     <= 1'b0;
`endif
      cnt_q      <= 8'd0;
      armed_q    <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 8'd0) begin
            ready_q <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StResp: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          armed_q <= 1'b0;
          state_q <= StIdle;
        end
        StInit: begin
`ifdef MEM_BLOCK_RESPONDER_INIT_EN
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == {MEM_INDEX_BITS{1'b1}}) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
      // A held-high enable must drop for an edge before another request is taken.
      if (!mem.mem_req_enable) begin
        armed_q <= 1'b1;
      end
    end
  end

  mem_block_ram #(
    .INDEX_BITS(MEM_INDEX_BITS),
    .DATA_WIDTH(BLOCK_DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .index(ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign mem.mem_req_datain = ram_rdata;
  assign mem.mem_req_ready  = ready_q;
  assign mem.mem_busy       = busy_q;
endmodule

// File: tb/tb_mem_block_responder.sv
// Randomized bench for mem_block_responder: transaction-level model plus directed literal checks.
module tb_mem_block_responder;
  localparam int LAT = 4;
  typedef logic [511:0] line_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_block_responder_if #(.WORD_SIZE(32), .BLOCK_DATA_WIDTH(512)) bus ();

  mem_block_responder #(
    .WORD_SIZE       (32),
    .BLOCK_OFFSET    (4),
    .BLOCK_DATA_WIDTH(512),
    .MEM_INDEX_BITS  (8),
    .LATENCY         (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem(bus)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;

  // Model state: transaction-level view of the memory.
  line_t mmem [int];
  bit    mvalid = 0;
  logic  e_ready = 0, e_busy = 0;
  line_t e_datain = '0;
  bit    e_dknown = 1;
  bit    armed = 1, pend = 0, p_rw = 0, initing = 0;
  int    p_idx = 0, resp_n = 0, init_i = 0;
  line_t p_data = '0;

  function automatic line_t pat_line(int i);
    line_t l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = 32'hDEADBEEF + 32'(i * 16 + w);
    return l;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic line_t cafe_line();
    line_t l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = 32'hCAFE0000 + 32'(w);
    return l;
  endfunction

  task automatic check_line(string name, line_t act, line_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Model: updated at every rising edge from the inputs sampled there.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mvalid = 1; e_ready = 0; e_datain = '0; e_dknown = 1; armed = 1; pend = 0;
`ifdef MEM_BLOCK_RESPONDER_INIT_EN
        initing = 1; init_i = 0; e_busy = 1;
`else
        e_busy = 0;
`endif
      end else begin
        if (initing) begin
          mmem[init_i] = pat_line(init_i);
          init_i++;
          if (init_i == 256) begin
            initing = 0; e_busy = 0;
          end
        end else if (e_ready) begin
          e_ready = 0; e_busy = 0; armed = 0; pend = 0;
        end else if (pend) begin
          if (cyc == resp_n) begin
            e_ready = 1;
            if (p_rw) mmem[p_idx] = p_data;
            else if (mmem.exists(p_idx)) begin
              e_datain = mmem[p_idx]; e_dknown = 1;
            end else e_dknown = 0;
          end
        end else if (bus.mem_req_enable && armed) begin
          pend = 1; e_busy = 1; resp_n = cyc + LAT;
          p_rw = bus.mem_req_rw;
          p_idx = int'((bus.mem_req_addr >> 6) % 256);
          p_data = bus.mem_req_dataout;
        end
        if (!bus.mem_req_enable) armed = 1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle once reset has been seen.
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        check_int("ready", int'(bus.mem_req_ready), int'(e_ready));
        check_int("busy", int'(bus.mem_busy), int'(e_busy));
        if (e_dknown) check_line("datain", bus.mem_req_datain, e_datain);
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 600; k++) begin
      if (!bus.mem_busy) break;
      @(negedge clk);
    end
    if (bus.mem_busy) check_int("idle_timeout", 1, 0);
  endtask

  // Issues one request from idle, holds it until ready, then drops enable.
  task automatic do_req(input logic rw, input logic [31:0] addr, input line_t data,
                        output int lat, output int bcyc, output line_t rdata);
    int t0;
    bit seen;
    @(negedge clk);
    bus.mem_req_enable = 1; bus.mem_req_rw = rw;
    bus.mem_req_addr = addr; bus.mem_req_dataout = data;
    @(posedge clk);
    #1 t0 = cyc;
    seen = 0; bcyc = 0; lat = -1; rdata = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_busy) bcyc++;
      if (bus.mem_req_ready) begin
        seen = 1; lat = cyc - t0; rdata = bus.mem_req_datain;
        bus.mem_req_enable = 0;
      end
    end
    if (!seen) begin
      check_int("ready_timeout", 0, 1);
      bus.mem_req_enable = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    line_t a, b, c, d, r;
    logic [31:0] w;
    int lat, bc, pulses, exp_bc;
    bit seen;
    rst = 1; bus.mem_req_enable = 0; bus.mem_req_rw = 0;
    bus.mem_req_addr = '0; bus.mem_req_dataout = '0;
    repeat (3) @(negedge clk);

    // Busy span after reset release.
    rst = 0; bc = 0;
    for (int k = 0; k < 600; k++) begin
      if (!bus.mem_busy) break;
      bc++;
      @(negedge clk);
    end
`ifdef MEM_BLOCK_RESPONDER_INIT_EN
    exp_bc = 256;
`else
    exp_bc = 0;
`endif
    check_int("post_reset_busy_cycles", bc, exp_bc);
`ifdef MEM_BLOCK_RESPONDER_INIT_EN
    do_req(0, 32'h0000_0C40, '0, lat, bc, r);
    w = r[31:0];
    check_int("init_word0", int'(w), int'(32'hDEADC1FF));
`endif

    // Write then read back a line.
    a = cafe_line();
    do_req(1, 32'h0000_0A80, a, lat, bc, r);
    check_int("wr_latency", lat, LAT);
    check_int("wr_busy_cycles", bc, LAT + 1);
    do_req(0, 32'h0000_0A80, '0, lat, bc, r);
    check_int("rd_latency", lat, LAT);
    check_int("rd_busy_cycles", bc, LAT + 1);
    w = r[5*32 +: 32];
    check_int("rd_word5", int'(w), int'(32'hCAFE0005));
    check_line("rd_line", r, a);

    // Enable held high: one response only until it drops for an edge.
    @(negedge clk);
    bus.mem_req_enable = 1; bus.mem_req_rw = 0; bus.mem_req_addr = 32'h0000_0A80;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req_ready) pulses++;
    end
    check_int("hold_pulses", pulses, 1);
    bus.mem_req_enable = 0;
    @(negedge clk);
    bus.mem_req_enable = 1; pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.mem_req_ready) pulses++;
    end
    check_int("rearm_pulses", pulses, 1);
    bus.mem_req_enable = 0;
    @(negedge clk);

    // Address aliasing modulo 16 KiB.
    b = rand_line();
    do_req(1, 32'h0000_0040, b, lat, bc, r);
    do_req(0, 32'h0000_4040, '0, lat, bc, r);
    check_line("alias_line", r, b);

    // Reset on the edge that would complete a write: write discarded, no ready.
    a = rand_line(); b = rand_line();
    do_req(1, 32'h0000_0100, a, lat, bc, r);
    @(negedge clk);
    bus.mem_req_enable = 1; bus.mem_req_rw = 1;
    bus.mem_req_addr = 32'h0000_0100; bus.mem_req_dataout = b;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_int("ready_at_reset", int'(bus.mem_req_ready), 0);
    rst = 0; bus.mem_req_enable = 0;
    @(negedge clk);
    wait_idle();
    do_req(0, 32'h0000_0100, '0, lat, bc, r);
`ifdef MEM_BLOCK_RESPONDER_INIT_EN
    check_line("reset_abort_line", r, pat_line(4));
`else
    check_line("reset_abort_line", r, a);
`endif

    // Inputs changed while busy are ignored.
    c = rand_line(); d = rand_line();
    do_req(1, 32'h0000_0200, c, lat, bc, r);
    do_req(1, 32'h0000_0300, d, lat, bc, r);
    @(negedge clk);
    bus.mem_req_enable = 1; bus.mem_req_rw = 0; bus.mem_req_addr = 32'h0000_0200;
    @(negedge clk);
    bus.mem_req_rw = 1; bus.mem_req_addr = 32'h0000_0300; bus.mem_req_dataout = rand_line();
    pulses = 0; seen = 0; r = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req_ready) begin
        pulses++;
        if (!seen) r = bus.mem_req_datain;
        seen = 1;
      end
    end
    check_int("latched_pulses", pulses, 1);
    check_line("latched_read_line", r, c);
    bus.mem_req_enable = 0;
    @(negedge clk);
    do_req(0, 32'h0000_0300, '0, lat, bc, r);
    check_line("latched_no_write", r, d);

    // Random traffic, checked cycle by cycle against the model.
    for (int t = 0; t < 250; t++) begin
      int idx_pool [8] = '{3, 4, 8'h31, 8'h2a, 1, 8'hff, 0, 8'h80};
      @(negedge clk);
      bus.mem_req_enable = 1;
      bus.mem_req_rw = 1'($urandom_range(0, 1));
      bus.mem_req_addr = ($urandom & 32'hFFFF_C000) |
                         (32'(idx_pool[$urandom_range(0, 7)]) << 6) | ($urandom & 32'h3F);
      bus.mem_req_dataout = rand_line();
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 39) == 0) begin
          rst = 1;
          @(negedge clk);
          rst = 0;
          break;
        end
        if ($urandom_range(0, 3) == 0) begin
          bus.mem_req_rw = 1'($urandom_range(0, 1));
          bus.mem_req_addr = $urandom;
          bus.mem_req_dataout = rand_line();
        end
        if (bus.mem_req_ready) begin
          if ($urandom_range(0, 4) == 0) repeat (3) @(negedge clk);
          break;
        end
      end
      bus.mem_req_enable = 0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      wait_idle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
